enum_name_parser: RTL and testbench

ENUM_NAME_PARSER -- requirements
Module: enum_name_parser

---
 rtl/enum_fmt_pkg.sv | 44 ++++
 rtl/enum_name_rom.sv | 17 +
 rtl/enum_name_parser.sv | 150 +++++++++++++++
 tb/tb_enum_name_parser.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/enum_fmt_pkg.sv
// enum_fmt_pkg
// Shared definitions for the enum name parser: the decoded state_e type,
// the parser FSM encoding, the token delimiters and the table of enum names
// the parser matches against.
// Ports: none (package).
// Optional feature: ENUM_PARSE_NUMERIC_EN is consumed by enum_name_parser.
package enum_fmt_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE = 2'b00,
    STATE_BUSY = 2'b01,
    STATE_DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    MATCH = 2'b01,
    EMIT  = 2'b10
  } fsm_e;

  localparam int NAME_LEN  = 10;
  localparam int NUM_NAMES = 3;

  localparam logic [7:0] DELIM_SPACE = 8'h20;
  localparam logic [7:0] DELIM_NL    = 8'h0A;

  // Error code presented on enum_val for a token that matches nothing.
  localparam logic [1:0] ERR_VAL = 2'b11;

  // Name e occupies bits [e*80 +: 80]; its first character sits in the
  // most significant byte of that slice, as a string literal lays it out.
  localparam logic [NUM_NAMES*NAME_LEN*8-1:0] NAME_TABLE =
    {"STATE_DONE", "STATE_BUSY", "STATE_IDLE"};

  function automatic logic [7:0] name_char(input logic [1:0] e, input logic [3:0] i);
    if (int'(e) >= NUM_NAMES || int'(i) >= NAME_LEN) return 8'h00;
    return NAME_TABLE[int'(e)*NAME_LEN*8 + (NAME_LEN-1-int'(i))*8 +: 8];
  endfunction

  function automatic logic is_delim(input logic [7:0] c);
    return (c == DELIM_SPACE) || (c == DELIM_NL);
  endfunction

endpackage

// File: rtl/enum_name_rom.sv
// enum_name_rom
// Purely combinational lookup of one character of an enum name.
// Ports:
//   enum_idx  - which name (0 = STATE_IDLE, 1 = STATE_BUSY, 2 = STATE_DONE)
//   char_idx  - character position within the name (0..9)
//   char_out  - ASCII byte at that position, 8'h00 when out of range
module enum_name_rom
  import enum_fmt_pkg::*;
(
  input  logic [1:0] enum_idx,
  input  logic [3:0] char_idx,
  output logic [7:0] char_out
);

  assign char_out = name_char(enum_idx, char_idx);

endmodule

// File: rtl/enum_name_parser.sv
// enum_name_parser
// Streams ASCII characters, splits them into tokens on space/newline and
// decodes each token into a state_e value, flagging unknown tokens.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   char_valid/char_ready - character input handshake, char_data = byte
//   enum_valid/enum_ready - result output handshake
//   enum_val, enum_err    - decoded value (2'b11 on error) and error flag
//   err_count             - saturating count of accepted error results
// Optional feature: define ENUM_PARSE_NUMERIC_EN to also accept the
// single-digit tokens "0", "1" and "2".
module enum_name_parser
  import enum_fmt_pkg::*;
#(
  parameter int MAX_TOKEN_LEN = 16,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 char_valid,
  input  logic [7:0]           char_data,
  output logic                 char_ready,
  output logic                 enum_valid,
  input  logic                 enum_ready,
  output logic [1:0]           enum_val,
  output logic                 enum_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int IDX_W = $clog2(MAX_TOKEN_LEN + 1);

  fsm_e             state;
  logic [IDX_W-1:0] index;
  logic [2:0]       mask;
  logic [7:0]       name_byte [NUM_NAMES];
  logic [3:0]       rom_idx;
  logic             in_range;
  logic             char_fire;
  logic             delim;
  logic [2:0]       next_mask;
  logic [IDX_W-1:0] next_index;
  logic [1:0]       res_val;
  logic             res_err;
`ifdef ENUM_PARSE_NUMERIC_EN
  logic [7:0]       first_char;
`endif

  assign char_fire = char_valid && char_ready;
  assign delim     = is_delim(char_data);
  assign in_range  = (int'(index) < NAME_LEN);
  assign rom_idx   = in_range ? 4'(index) : 4'd0;

  // One lookup per candidate name, all indexed by the current position.
  for (genvar g = 0; g < NUM_NAMES; g++) begin : g_rom
    enum_name_rom u_rom (
      .enum_idx (2'(g)),
      .char_idx (rom_idx),
      .char_out (name_byte[g])
    );
  end

  // A candidate survives only while every character so far matched and the
  // token has not grown past the name length.
  always_comb begin
    next_mask = 3'b000;
    for (int k = 0; k < NUM_NAMES; k++) begin
      next_mask[k] = mask[k] && in_range && (char_data == name_byte[k]);
    end
    next_index = (int'(index) < MAX_TOKEN_LEN) ? index + 1'b1 : index;
  end

  // Decode the finished token; anything not exactly one full-length match
  // becomes an error.
  always_comb begin
    res_val = ERR_VAL;
    res_err = 1'b1;
    if ((int'(index) == NAME_LEN) && $onehot(mask)) begin
      res_err = 1'b0;
      unique case (mask)
        3'b001:  res_val = STATE_IDLE;
        3'b010:  res_val = STATE_BUSY;
        default: res_val = STATE_DONE;
      endcase
    end
`ifdef ENUM_PARSE_NUMERIC_EN
    else if ((int'(index) == 1) && (first_char >= "0") && (first_char <= "2")) begin
      res_err = 1'b0;
      res_val = first_char[1:0];
    end
`endif
  end

  // Parser FSM; char_ready is registered so it drops exactly while a
  // result is waiting in EMIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      index      <= '0;
      mask       <= 3'b111;
      char_ready <= 1'b1;
      enum_valid <= 1'b0;
      enum_val   <= 2'b00;
      enum_err   <= 1'b0;
      err_count  <= '0;
`ifdef ENUM_PARSE_NUMERIC_EN
      first_char <= 8'h00;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          // Delimiters between tokens are simply dropped here.
          if (char_fire && !delim) begin
            mask  <= next_mask;
            index <= next_index;
`ifdef ENUM_PARSE_NUMERIC_EN
            first_char <= char_data;
`endif
            state <= MATCH;
          end
        end
        MATCH: begin
          if (char_fire) begin
            if (delim) begin
              enum_val   <= res_val;
              enum_err   <= res_err;
              enum_valid <= 1'b1;
              char_ready <= 1'b0;
              state      <= EMIT;
            end else begin
              mask  <= next_mask;
              index <= next_index;
            end
          end
        end
        EMIT: begin
          if (enum_ready) begin
            enum_valid <= 1'b0;
            char_ready <= 1'b1;
            if (enum_err && (err_count != '1)) err_count <= err_count + 1'b1;
            index <= '0;
            mask  <= 3'b111;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enum_name_parser.sv
// tb_enum_name_parser
// Directed scoreboard bench for enum_name_parser: stimulus pushes the
// expected {err, val} of every token it sends, and a monitor pops and
// compares on each result handshake.
// Ports: none (top-level bench). Honours ENUM_PARSE_NUMERIC_EN.
module tb_enum_name_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic       enum_valid;
  logic       enum_ready = 1'b1;
  logic [1:0] enum_val;
  logic       enum_err;
  logic [7:0] err_count;

  int total = 0;
  int bad = 0;
  int result_count = 0;
  int base_count;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  enum_name_parser #(.MAX_TOKEN_LEN(16), .ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .enum_valid (enum_valid),
    .enum_ready (enum_ready),
    .enum_val   (enum_val),
    .enum_err   (enum_err),
    .err_count  (err_count)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every result handshake is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && enum_valid && enum_ready) begin
      result_count++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_result: got val=%0d err=%0d expected none", enum_val, enum_err);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        checkOutput("result_val", 32'(enum_val), 32'(e[1:0]));
        checkOutput("result_err", 32'(enum_err), 32'(e[2]));
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pushExp(input logic [1:0] val, input logic err);
    exp_q.push_back({err, val});
  endtask

  // Called 1 time unit after a rising edge; char_ready is stable until the
  // next edge, so its value now is what the DUT sees at that edge.
  task automatic sendChar(input logic [7:0] c);
    int n;
    logic seen;
    n = 0;
    char_valid = 1'b1;
    char_data  = c;
    do begin
      seen = char_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!seen && n < 50);
    char_valid = 1'b0;
    if (!seen) begin
      total++;
      bad++;
      $display("[TB] FAIL char_timeout: got no handshake expected handshake for 0x%02h", c);
    end
  endtask

  task automatic applyStimulus(input string s);
    for (int i = 0; i < s.len(); i++) sendChar(s[i]);
  endtask

  initial begin
    waitCycles(2);
    rst_n = 1'b1;
    checkOutput("reset_char_ready", 32'(char_ready), 1);
    checkOutput("reset_enum_valid", 32'(enum_valid), 0);
    checkOutput("reset_enum_val", 32'(enum_val), 0);
    checkOutput("reset_enum_err", 32'(enum_err), 0);
    checkOutput("reset_err_count", 32'(err_count), 0);

    // Valid name with one-cycle latency after the newline handshake.
    pushExp(2'b01, 1'b0);
    applyStimulus("STATE_BUSY\n");
    checkOutput("latency_valid", 32'(enum_valid), 1);
    checkOutput("latency_char_ready", 32'(char_ready), 0);
    waitCycles(2);
    checkOutput("valid_cleared", 32'(enum_valid), 0);

    // Too short and too long tokens are both errors.
    pushExp(2'b11, 1'b1);
    pushExp(2'b11, 1'b1);
    applyStimulus("STATE_IDL \n");
    applyStimulus("STATE_DONEX ");
    waitCycles(3);
    checkOutput("err_count_two", 32'(err_count), 2);

    // Backpressure: the result must be held and input stalled.
    enum_ready = 1'b0;
    base_count = result_count;
    pushExp(2'b10, 1'b0);
    applyStimulus("STATE_DONE ");
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", 32'(enum_valid), 1);
      checkOutput("hold_val", 32'(enum_val), 2);
      checkOutput("hold_char_ready", 32'(char_ready), 0);
      waitCycles(1);
    end
    enum_ready = 1'b1;
    waitCycles(4);
    checkOutput("hold_one_result", 32'(result_count - base_count), 1);

    // Leading delimiters must not produce empty-token results.
    base_count = result_count;
    pushExp(2'b00, 1'b0);
    applyStimulus("  \n\nSTATE_IDLE\n");
    waitCycles(3);
    checkOutput("empty_tokens_one_result", 32'(result_count - base_count), 1);

    // Reset mid-token discards the partial token and clears the counter.
    applyStimulus("STATE_");
    rst_n = 1'b0;
    waitCycles(1);
    rst_n = 1'b1;
    checkOutput("post_reset_char_ready", 32'(char_ready), 1);
    checkOutput("post_reset_valid", 32'(enum_valid), 0);
    checkOutput("post_reset_err_count", 32'(err_count), 0);
    base_count = result_count;
    pushExp(2'b01, 1'b0);
    applyStimulus("STATE_BUSY\n");
    waitCycles(3);
    checkOutput("post_reset_one_result", 32'(result_count - base_count), 1);
    checkOutput("post_reset_err_count_after", 32'(err_count), 0);

    // Single-digit tokens.
`ifdef ENUM_PARSE_NUMERIC_EN
    pushExp(2'b10, 1'b0);
    pushExp(2'b11, 1'b1);
    applyStimulus("2 3 ");
    waitCycles(3);
    checkOutput("digit_err_count", 32'(err_count), 1);
`else
    pushExp(2'b11, 1'b1);
    pushExp(2'b11, 1'b1);
    applyStimulus("2 3 ");
    waitCycles(3);
    checkOutput("digit_err_count", 32'(err_count), 2);
`endif

    waitCycles(2);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
